ball_physics: RTL and testbench

Parametrised successor to the first-generation Pong ball logic. Moves the ball on each `timing_tick` and bounces it off the top and bottom walls and both paddles. Adds a serve/miss state machine, one-tick miss and hit pulses, and a speed that steps up with rally length. Sits between the paddle controllers (inputs: paddle Y) and the draw/score logic (outputs: ball X/Y, miss pulses).

---
 rtl/ball_pkg.sv | 21 ++
 rtl/vga_pkg.sv | 7 +
 rtl/serve_timer.sv | 39 +++
 rtl/ball_physics.sv | 241 ++++++++++++++++++++++++
 tb/tb_ball_physics.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_pkg.sv
// Ball physics types and helpers: game state encoding, screen size, centring.
package ball_pkg;

    // Screen dimensions come from the video timing package
    localparam int SCREEN_W = vga_pkg::HOR_PIXELS;
    localparam int SCREEN_H = vga_pkg::VER_PIXELS;

    // Game state of the ball
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        MISS  = 2'd3
    } ball_state_t;

    // Top-left coordinate that centres an object of size obj in an axis of pix pixels
    function automatic int centre(input int pix, input int obj);
        return (pix - obj) / 2;
    endfunction

endpackage : ball_pkg

// File: rtl/vga_pkg.sv
// Shared video timing constants: visible screen size in pixels.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

endpackage : vga_pkg

// File: rtl/serve_timer.sv
// Tick-gated serve counter: clears synchronously, flags the final serve tick.
module serve_timer #(
    parameter int SERVE_TICKS = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count ticks and hold at the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule : serve_timer

// File: rtl/ball_physics.sv
// Pong ball: serve/miss state machine, wall and paddle bounces, rally speed-up.
module ball_physics
    import ball_pkg::*;
#(
    parameter int H_PIX         = SCREEN_W,
    parameter int V_PIX         = SCREEN_H,
    parameter int BALL_SIZE     = 15,
    parameter int PAD_H         = 72,
    parameter int PAD_W         = 15,
    parameter int X_PAD_L       = 30,
    parameter int X_PAD_R       = 979,
    parameter int V_INIT        = 2,
    parameter int V_MAX         = 8,
    parameter int HITS_PER_STEP = 4,
    parameter int SERVE_TICKS   = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        game_en,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [10:0] y_ball,
    output logic        miss_left,
    output logic        miss_right,
    output logic        hit,
    output logic [3:0]  speed,
    output logic        serving
);

    // Geometry in 12 bits so sums of coordinate, size and speed never wrap
    localparam logic [10:0] XC      = 11'(centre(H_PIX, BALL_SIZE));
    localparam logic [10:0] YC      = 11'(centre(V_PIX, BALL_SIZE));
    localparam logic [11:0] H12     = 12'(H_PIX);
    localparam logic [11:0] BALL12  = 12'(BALL_SIZE);
    localparam logic [11:0] PADH12  = 12'(PAD_H);
    localparam logic [11:0] YMAX12  = 12'(V_PIX - BALL_SIZE);
    localparam logic [11:0] PL_X12  = 12'(X_PAD_L);
    localparam logic [11:0] PL_E12  = 12'(X_PAD_L + PAD_W);
    localparam logic [11:0] PR_X12  = 12'(X_PAD_R);
    localparam logic [11:0] PR_E12  = 12'(X_PAD_R + PAD_W);
    localparam logic [10:0] YMAX    = 11'(V_PIX - BALL_SIZE);
    localparam logic [10:0] PL_STOP = 11'(X_PAD_L + PAD_W);
    localparam logic [10:0] PR_STOP = 11'(X_PAD_R - BALL_SIZE);
    localparam logic [3:0]  VINIT4  = 4'(V_INIT);
    localparam logic [3:0]  VMAX4   = 4'(V_MAX);
    localparam int          HC_W    = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HITS_PER_STEP - 1);

    ball_state_t     state_q, state_d;
    logic [10:0]     x_q, x_d;
    logic [10:0]     y_q, y_d;
    logic [3:0]      speed_q, speed_d;
    logic [HC_W-1:0] hit_cnt_q, hit_cnt_d;
    logic            dir_right_q, dir_right_d;
    logic            dir_down_q, dir_down_d;
    logic            miss_left_q, miss_left_d;
    logic            miss_right_q, miss_right_d;
    logic            hit_q, hit_d;
    logic            serving_q, serving_d;

    logic [11:0]     x12, y12, v12, pl12, pr12;
    logic [10:0]     v11;
    logic            ovl_left, ovl_right;
    logic            serve_clr, serve_done;

    assign x12  = {1'b0, x_q};
    assign y12  = {1'b0, y_q};
    assign v12  = {8'b0, speed_q};
    assign v11  = {7'b0, speed_q};
    assign pl12 = {2'b0, y_pad_left};
    assign pr12 = {2'b0, y_pad_right};

    // Vertical overlap of the ball with each paddle
    always_comb begin
        ovl_left  = ((y12 + BALL12) > pl12) && (y12 < (pl12 + PADH12));
        ovl_right = ((y12 + BALL12) > pr12) && (y12 < (pr12 + PADH12));
    end

    // Serve counter runs only while serving; any other state holds it at zero
    assign serve_clr = (state_q != SERVE);

    serve_timer #(
        .SERVE_TICKS(SERVE_TICKS)
    ) u_serve_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (serve_clr),
        .tick (timing_tick),
        .done (serve_done)
    );

    // Next-state, motion, speed and pulse logic
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        speed_d      = speed_q;
        hit_cnt_d    = hit_cnt_q;
        dir_right_d  = dir_right_q;
        dir_down_d   = dir_down_q;
        miss_left_d  = 1'b0;
        miss_right_d = 1'b0;
        hit_d        = 1'b0;

        if (!game_en) begin
            state_d = IDLE;
            x_d     = XC;
            y_d     = YC;
        end else if (timing_tick) begin
            unique case (state_q)
                IDLE: begin
                    state_d = SERVE;
                    x_d     = XC;
                    y_d     = YC;
                end

                SERVE: begin
                    x_d = XC;
                    y_d = YC;
                    if (serve_done) begin
                        state_d = PLAY;
                    end
                end

                // dir_right already points at the side that missed, so the
                // serve heads toward the loser without extra state
                MISS: begin
                    state_d    = SERVE;
                    x_d        = XC;
                    y_d        = YC;
                    speed_d    = VINIT4;
                    hit_cnt_d  = '0;
                    dir_down_d = ~dir_down_q;
                end

                PLAY: begin
                    // Top and bottom walls
                    if (dir_down_q) begin
                        if ((y12 + v12) >= YMAX12) begin
                            y_d        = YMAX;
                            dir_down_d = 1'b0;
                        end else begin
                            y_d = y_q + v11;
                        end
                    end else begin
                        if (y12 <= v12) begin
                            y_d        = '0;
                            dir_down_d = 1'b1;
                        end else begin
                            y_d = y_q - v11;
                        end
                    end

                    // Paddles and misses
                    if (!dir_right_q) begin
                        if ((x12 <= (PL_E12 + v12)) && (x12 > PL_X12) && ovl_left) begin
                            x_d         = PL_STOP;
                            dir_right_d = 1'b1;
                            hit_d       = 1'b1;
                        end else if (x12 <= v12) begin
                            miss_left_d = 1'b1;
                            state_d     = MISS;
                        end else begin
                            x_d = x_q - v11;
                        end
                    end else begin
                        if (((x12 + BALL12 + v12) >= PR_X12) &&
                            ((x12 + BALL12) < PR_E12) && ovl_right) begin
                            x_d         = PR_STOP;
                            dir_right_d = 1'b0;
                            hit_d       = 1'b1;
                        end else if ((x12 + BALL12 + v12) >= H12) begin
                            miss_right_d = 1'b1;
                            state_d      = MISS;
                        end else begin
                            x_d = x_q + v11;
                        end
                    end

                    // Rally speed-up
                    if (hit_d) begin
                        if (hit_cnt_q == HC_LAST) begin
                            hit_cnt_d = '0;
                            if (speed_q < VMAX4) begin
                                speed_d = speed_q + 4'd1;
                            end
                        end else begin
                            hit_cnt_d = hit_cnt_q + HC_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        serving_d = (state_d == IDLE) || (state_d == SERVE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= XC;
            y_q          <= YC;
            speed_q      <= VINIT4;
            hit_cnt_q    <= '0;
            dir_right_q  <= 1'b0;
            dir_down_q   <= 1'b0;
            miss_left_q  <= 1'b0;
            miss_right_q <= 1'b0;
            hit_q        <= 1'b0;
            serving_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            speed_q      <= speed_d;
            hit_cnt_q    <= hit_cnt_d;
            dir_right_q  <= dir_right_d;
            dir_down_q   <= dir_down_d;
            miss_left_q  <= miss_left_d;
            miss_right_q <= miss_right_d;
            hit_q        <= hit_d;
            serving_q    <= serving_d;
        end
    end

    assign x_ball     = x_q;
    assign y_ball     = y_q;
    assign speed      = speed_q;
    assign miss_left  = miss_left_q;
    assign miss_right = miss_right_q;
    assign hit        = hit_q;
    assign serving    = serving_q;

endmodule : ball_physics

// File: tb/tb_ball_physics.sv
// Self-checking bench for ball_physics: vector table, scoreboard against a
// behavioural model, and hand-written serve/hit/miss/disable/reset sequences.
module tb_ball_physics;

    localparam int XC = 504;
    localparam int YC = 376;
    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_tick;
    logic        game_en;
    logic [9:0]  y_pad_left, y_pad_right;
    logic [10:0] x_ball, y_ball;
    logic        miss_left, miss_right, hit, serving;
    logic [3:0]  speed;

    always #5 clk = ~clk;

    ball_physics dut (
        .clk         (clk),
        .rst         (rst),
        .timing_tick (timing_tick),
        .game_en     (game_en),
        .y_pad_left  (y_pad_left),
        .y_pad_right (y_pad_right),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .hit         (hit),
        .speed       (speed),
        .serving     (serving)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  spd;
        logic        srv;
        logic        hit;
        logic        ml;
        logic        mr;
    } obs_t;

    typedef struct {
        bit tk;
        bit en;
        int ex;
        int ey;
        int esp;
        int esrv;
    } vec_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model state
    int m_st, m_x, m_y, m_v, m_hc, m_dr, m_dd, m_cnt;
    int m_hit, m_ml, m_mr, ev_top, ev_bot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_x = XC; m_y = YC; m_v = 2; m_hc = 0;
        m_dr = 0; m_dd = 0; m_cnt = 0;
        m_hit = 0; m_ml = 0; m_mr = 0; ev_top = 0; ev_bot = 0;
    endtask

    task automatic model_step(input bit tk);
        int nx, ny, ndr, ndd, pl, pr;
        bit ovl, ovr;
        m_hit = 0; m_ml = 0; m_mr = 0; ev_top = 0; ev_bot = 0;
        pl = int'(y_pad_left);
        pr = int'(y_pad_right);
        if (!game_en) begin
            m_st = S_IDLE; m_x = XC; m_y = YC;
        end else if (tk) begin
            case (m_st)
                S_IDLE:  begin m_st = S_SERVE; m_cnt = 0; end
                S_SERVE: begin
                    if (m_cnt == 59) m_st = S_PLAY;
                    else m_cnt++;
                end
                S_MISS: begin
                    m_x = XC; m_y = YC; m_v = 2; m_hc = 0; m_dd = 1 - m_dd;
                    m_st = S_SERVE; m_cnt = 0;
                end
                default: begin
                    ovl = (m_y + 15 > pl) && (m_y < pl + 72);
                    ovr = (m_y + 15 > pr) && (m_y < pr + 72);
                    nx = m_x; ny = m_y; ndr = m_dr; ndd = m_dd;
                    if (m_dd != 0) begin
                        if (m_y + m_v >= 753) begin ny = 753; ndd = 0; ev_bot = 1; end
                        else ny = m_y + m_v;
                    end else begin
                        if (m_y - m_v <= 0) begin ny = 0; ndd = 1; ev_top = 1; end
                        else ny = m_y - m_v;
                    end
                    if (m_dr == 0) begin
                        if (m_x - m_v <= 45 && m_x > 30 && ovl) begin
                            nx = 45; ndr = 1; m_hit = 1;
                        end else if (m_x - m_v <= 0) begin
                            m_ml = 1; m_st = S_MISS;
                        end else nx = m_x - m_v;
                    end else begin
                        if (m_x + 15 + m_v >= 979 && m_x + 15 < 994 && ovr) begin
                            nx = 964; ndr = 0; m_hit = 1;
                        end else if (m_x + 15 + m_v >= 1024) begin
                            m_mr = 1; m_st = S_MISS;
                        end else nx = m_x + m_v;
                    end
                    if (m_hit != 0) begin
                        if (m_hc == 3) begin
                            m_hc = 0;
                            if (m_v < 8) m_v++;
                        end else m_hc++;
                    end
                    m_x = nx; m_y = ny; m_dr = ndr; m_dd = ndd;
                end
            endcase
        end
    endtask

    // One clock: drive, predict into the scoreboard, then sample and compare
    task automatic cycle(input bit tk);
        obs_t e, a;
        timing_tick = tk;
        model_step(tk);
        e.x   = 11'(m_x);
        e.y   = 11'(m_y);
        e.spd = 4'(m_v);
        e.srv = (m_st == S_IDLE) || (m_st == S_SERVE);
        e.hit = (m_hit != 0);
        e.ml  = (m_ml != 0);
        e.mr  = (m_mr != 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        timing_tick = 1'b0;
        a = {x_ball, y_ball, speed, serving, hit, miss_left, miss_right};
        e = sb_q.pop_front();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL scoreboard t=%0t x=%0d/%0d y=%0d/%0d spd=%0d/%0d srv=%0b/%0b hit=%0b/%0b ml=%0b/%0b mr=%0b/%0b (actual/required)",
                     $time, a.x, e.x, a.y, e.y, a.spd, e.spd, a.srv, e.srv,
                     a.hit, e.hit, a.ml, e.ml, a.mr, e.mr);
        end
    endtask

    function automatic logic [9:0] track(input int y);
        return (y < 20) ? 10'd0 : 10'(y - 20);
    endfunction

    task automatic serve_run(input string tag);
        for (int i = 1; i <= 60; i++) begin
            cycle(1'b1);
            if (i == 59) check({tag, "_serve_hold"}, serving, 1);
            if (i == 60) check({tag, "_serve_fall"}, serving, 0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int  hits;
        bit  first;
        bit  done;
        int  dd_before;

        vecs[0] = '{tk: 1'b0, en: 1'b0, ex: XC, ey: YC, esp: 2, esrv: 1};
        vecs[1] = '{tk: 1'b1, en: 1'b0, ex: XC, ey: YC, esp: 2, esrv: 1};
        vecs[2] = '{tk: 1'b0, en: 1'b1, ex: XC, ey: YC, esp: 2, esrv: 1};
        vecs[3] = '{tk: 1'b1, en: 1'b1, ex: XC, ey: YC, esp: 2, esrv: 1};
        vecs[4] = '{tk: 1'b0, en: 1'b1, ex: XC, ey: YC, esp: 2, esrv: 1};

        rst = 1'b1; timing_tick = 1'b0; game_en = 1'b0;
        y_pad_left = '0; y_pad_right = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_x", x_ball, XC);
        check("reset_y", y_ball, YC);
        check("reset_speed", speed, 2);
        check("reset_serving", serving, 1);
        check("reset_pulses", {hit, miss_left, miss_right}, 0);

        // Idle / enable vectors up to entering SERVE
        for (int i = 0; i < 5; i++) begin
            game_en = vecs[i].en;
            cycle(vecs[i].tk);
            check("vec_x", x_ball, vecs[i].ex);
            check("vec_y", y_ball, vecs[i].ey);
            check("vec_speed", speed, vecs[i].esp);
            check("vec_serving", serving, vecs[i].esrv);
        end

        serve_run("first");
        cycle(1'b1);
        check("launch_x", x_ball, 502);
        check("launch_y", y_ball, 374);

        // Rally with both paddles tracking the ball
        hits = 0; first = 1'b1;
        for (int i = 0; i < 6000 && hits < 4; i++) begin
            y_pad_left  = track(m_y);
            y_pad_right = track(m_y);
            cycle(1'b1);
            if (m_hit != 0) begin
                hits++;
                if (first) begin
                    check("first_hit_x", x_ball, 45);
                    check("first_hit_pulse", hit, 1);
                    first = 1'b0;
                end
            end
            if (ev_top != 0) check("top_clamp", y_ball, 0);
            if (ev_bot != 0) check("bottom_clamp", y_ball, 753);
        end
        check("hits_reached", hits, 4);
        check("speed_step", speed, 3);

        // Left paddle kept away from the ball until it misses
        done = 1'b0; dd_before = 0;
        for (int i = 0; i < 6000 && !done; i++) begin
            y_pad_left  = (m_y < 300) ? 10'd600 : 10'd0;
            y_pad_right = track(m_y);
            cycle(1'b1);
            if (m_ml != 0) begin
                done = 1'b1;
                dd_before = m_dd;
                check("miss_left_pulse", miss_left, 1);
                check("miss_no_hit", hit, 0);
            end
            if (ev_top != 0) check("top_clamp", y_ball, 0);
            if (ev_bot != 0) check("bottom_clamp", y_ball, 753);
        end
        check("miss_seen", done, 1);
        cycle(1'b1);
        check("miss_recentre_x", x_ball, XC);
        check("miss_recentre_y", y_ball, YC);
        check("miss_speed", speed, 2);
        check("miss_pulse_gone", miss_left, 0);
        serve_run("after_miss");
        cycle(1'b1);
        check("reserve_x", x_ball, 502);
        check("reserve_y", y_ball, (dd_before != 0) ? 374 : 378);

        // Disable mid-play, stay frozen through ticks, then full serve again
        repeat (10) cycle(1'b1);
        game_en = 1'b0;
        cycle(1'b0);
        check("disable_x", x_ball, XC);
        check("disable_y", y_ball, YC);
        check("disable_serving", serving, 1);
        repeat (5) cycle(1'b1);
        check("frozen_x", x_ball, XC);
        game_en = 1'b1;
        cycle(1'b1);
        serve_run("reenable");
        repeat (5) cycle(1'b1);

        // Asynchronous reset between clock edges during play
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_x", x_ball, XC);
        check("async_rst_y", y_ball, YC);
        check("async_rst_speed", speed, 2);
        check("async_rst_serving", serving, 1);
        check("async_rst_pulses", {hit, miss_left, miss_right}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1);
        cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ball_physics
